pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencing and hazard controller for the 5-stage pipeline. It drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It runs the pipeline in continuous or single-step mode under debug-unit command, stalls on load-use hazards and flushes IF/ID on taken branches. On a HALT instruction it drains the pipeline and reports halted.

## Interface
- DRAIN_CYCLES, 3: cycles needed to retire the instructions in EX, MEM and WB after a HALT is decoded in ID.
- NB_REG, 5: register address width.
- NB_CYCLES, 32: cycle counter width.

- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_run  in  1  debug pulse: start continuous execution.
- i_step  in  1  debug pulse: execute exactly one clock.
- i_halt_instr  in  1  the instruction in ID is HALT.
- i_branch_taken  in  1  the branch or jump in ID resolved taken.
- i_idex_mem_read  in  1  the instruction in ID/EX is a load.
- i_idex_rt  in  NB_REG  destination register of the instruction in ID/EX.
- i_ifid_rs, i_ifid_rt  in  NB_REG  source registers of the instruction in IF/ID.
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1  stage enables.
- o_ifid_flush  out  1  IF/ID loads all-zero (NOP).
- o_idex_bubble  out  1  ID/EX loads NOP controls.
- o_halted  out  1  the pipeline has drained after HALT.
- o_busy  out  1  state is RUN, STEP or DRAIN.
- o_cycle_count  out  NB_CYCLES  count of clocks executed.

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. The state register and counters are registered. Controls are combinational functions of the state and current inputs.
- hazard = i_idex_mem_read & (i_idex_rt != 0) & (i_idex_rt == i_ifid_rs | i_idex_rt == i_ifid_rt).
- IDLE:
  - All enables, flush and bubble are 0.
  - i_run → RUN. i_step → STEP. If both are asserted, i_run wins.
- RUN and STEP ("active rules"):
  - Default: all five enables are 1.
  - If hazard: o_pc_en=0, o_ifid_en=0, o_idex_bubble=1. EX/MEM and MEM/WB stay enabled. Hazard beats branch (o_ifid_flush=0) and beats halt.
  - Else if i_halt_instr: o_pc_en=0, o_ifid_en=0, o_idex_bubble=1. Load the drain counter with DRAIN_CYCLES-1. Next state is DRAIN. Halt beats branch.
  - Else if i_branch_taken: o_ifid_flush=1 and all enables stay 1.
  - STEP returns to IDLE after one cycle unless halt was taken.
  - i_step during RUN is ignored. i_run during STEP is ignored.
- DRAIN:
  - o_pc_en=0, o_ifid_en=0, o_idex_en=1 with o_idex_bubble=1, o_exmem_en=1, o_memwb_en=1.
  - Decrement the counter each cycle. At count 0, go to HALTED next.
  - i_run, i_step, hazard and branch are ignored.
- HALTED:
  - All enables are 0 and o_halted=1.
  - The block stays here until i_reset is low. i_run and i_step are ignored.
- o_cycle_count increments by 1 on every clock spent in RUN, STEP or DRAIN. It saturates at all-ones and never wraps.
- Reset (i_reset low at a rising edge):
  - State becomes IDLE; the counter and drain counter become 0.
  - While i_reset is low, every output is forced to 0: enables, flush, bubble, o_halted, o_busy.
  - Reset applies from any state, including mid-DRAIN.

## Timing
- i_run or i_step sampled at edge t: state changes at t. The first active-rule cycle is t..t+1, so enables go high in the cycle after the pulse.
- Hazard and branch act in the same cycle they are asserted (zero latency). A stall lasts exactly as long as hazard is true; for a single load-use this is one cycle.
- HALT decoded in cycle c: DRAIN occupies cycles c+1 .. c+DRAIN_CYCLES. o_halted rises in cycle c+DRAIN_CYCLES+1.
- o_busy and o_halted are decoded from the registered state, so they are glitch-free.

## Test plan
- Reset held low 3 cycles with i_run=1 → every output 0 and o_cycle_count=0. After reset releases, still IDLE with no enables until a new i_run pulse.
- i_run pulse, then 10 free cycles → all enables 1 from the cycle after the pulse, and o_cycle_count=10.
- In RUN, set i_idex_mem_read=1, i_idex_rt=5, i_ifid_rt=5 for 1 cycle → that cycle o_pc_en=0, o_ifid_en=0, o_idex_bubble=1, o_exmem_en=1. With i_idex_rt=0 instead → no stall.
- Hazard and i_branch_taken together → stall wins and o_ifid_flush=0. Branch alone → o_ifid_flush=1 with o_pc_en=1.
- Three i_step pulses spaced 4 cycles apart → exactly 3 single-cycle enable windows, o_cycle_count=3, state back in IDLE after each.
- i_halt_instr in RUN at cycle c (DRAIN_CYCLES=3) → bubble in c..c+3, o_halted=1 from c+4. Later i_run is ignored. A reset pulse in cycle c+2 instead → IDLE with o_halted never asserting.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and the debug unit / decode stage.
// The controller uses the slave modport; the master drives the request side.
interface pipeline_ctrl_if #(
    parameter int unsigned NB_REG    = 5,
    parameter int unsigned NB_CYCLES = 32
);
    logic                 i_run;
    logic                 i_step;
    logic                 i_halt_instr;
    logic                 i_branch_taken;
    logic                 i_idex_mem_read;
    logic [NB_REG-1:0]    i_idex_rt;
    logic [NB_REG-1:0]    i_ifid_rs;
    logic [NB_REG-1:0]    i_ifid_rt;
    logic                 o_pc_en;
    logic                 o_ifid_en;
    logic                 o_idex_en;
    logic                 o_exmem_en;
    logic                 o_memwb_en;
    logic                 o_ifid_flush;
    logic                 o_idex_bubble;
    logic                 o_halted;
    logic                 o_busy;
    logic [NB_CYCLES-1:0] o_cycle_count;

    modport master (
        output i_run, i_step, i_halt_instr, i_branch_taken, i_idex_mem_read,
               i_idex_rt, i_ifid_rs, i_ifid_rt,
        input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
               o_ifid_flush, o_idex_bubble, o_halted, o_busy, o_cycle_count
    );

    modport slave (
        input  i_run, i_step, i_halt_instr, i_branch_taken, i_idex_mem_read,
               i_idex_rt, i_ifid_rs, i_ifid_rt,
        output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
               o_ifid_flush, o_idex_bubble, o_halted, o_busy, o_cycle_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage pipeline: run/step control,
// load-use stalls, branch flushes and HALT drain.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned NB_CYCLES    = 32
) (
    input logic              i_clk,
    input logic              i_reset,
    pipeline_ctrl_if.slave   bus
);
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StRun, StStep, StDrain, StHalted} state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [NB_CYCLES-1:0] cycle_q, cycle_d;

    logic hazard;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_bubble, halted, busy;

    assign hazard = bus.i_idex_mem_read && (bus.i_idex_rt != '0) &&
                    ((bus.i_idex_rt == bus.i_ifid_rs) || (bus.i_idex_rt == bus.i_ifid_rt));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_run) begin
                    state_d = StRun;
                end else if (bus.i_step) begin
                    state_d = StStep;
                end
            end
            StRun, StStep: begin
                busy     = 1'b1;
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (state_q == StStep) begin
                    state_d = StIdle;
                end
                // Priority: load-use stall, then HALT, then branch flush.
                if (hazard) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.i_halt_instr) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    drain_d     = DW'(DRAIN_CYCLES - 1);
                    state_d     = StDrain;
                end else if (bus.i_branch_taken) begin
                    ifid_flush = 1'b1;
                end
            end
            StDrain: begin
                busy        = 1'b1;
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                if (drain_q == '0) begin
                    state_d = StHalted;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cycle_d = cycle_q;
        if (((state_q == StRun) || (state_q == StStep) || (state_q == StDrain)) && !(&cycle_q)) begin
            cycle_d = cycle_q + NB_CYCLES'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= StIdle;
            drain_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cycle_q <= cycle_d;
        end
    end

    // Reset overrides every control combinationally, independent of state.
    assign bus.o_pc_en       = i_reset & pc_en;
    assign bus.o_ifid_en     = i_reset & ifid_en;
    assign bus.o_idex_en     = i_reset & idex_en;
    assign bus.o_exmem_en    = i_reset & exmem_en;
    assign bus.o_memwb_en    = i_reset & memwb_en;
    assign bus.o_ifid_flush  = i_reset & ifid_flush;
    assign bus.o_idex_bubble = i_reset & idex_bubble;
    assign bus.o_halted      = i_reset & halted;
    assign bus.o_busy        = i_reset & busy;
    assign bus.o_cycle_count = cycle_q;
endmodule
